// File: rtl/crossing_period_if.sv
// crossing_period_if -- sample stream in, period result out, plus status.
//   in_valid / in_data : filtered sample stream (producer -> detector)
//   out_valid / out_ready / out_period : result handshake (detector -> consumer)
//   stalled : no rotation detected
//   overrun : sticky, an unconsumed result was overwritten
// The master modport is the environment side; the slave modport is the
// period detector.
interface crossing_period_if #(
  parameter int unsigned DATA_WIDTH   = 20,
  parameter int unsigned PERIOD_WIDTH = 32
);
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [PERIOD_WIDTH-1:0] out_period;
  logic                    stalled;
  logic                    overrun;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_period, stalled, overrun
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_period, stalled, overrun
  );
endinterface

// File: rtl/crossing_period.sv
// crossing_period -- measures clk cycles between successive rising crossings
// of a hysteresis comparator on a filtered sample stream.
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : crossing_period_if slave (samples in, period/handshake/status out)
// A period of 0 is the zero-speed token emitted when no crossing arrives
// within TIMEOUT cycles of the last one.
module crossing_period #(
  parameter int unsigned DATA_WIDTH   = 20,
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned THRESH_HI    = 1000,
  parameter int unsigned THRESH_LO    = 800,
  parameter int unsigned TIMEOUT      = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  crossing_period_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0]   HI  = DATA_WIDTH'(THRESH_HI);
  localparam logic [DATA_WIDTH-1:0]   LO  = DATA_WIDTH'(THRESH_LO);
  localparam logic [PERIOD_WIDTH-1:0] TMO = PERIOD_WIDTH'(TIMEOUT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nx;
  logic [PERIOD_WIDTH-1:0] timer, timer_nx;
  logic                    lvl;
  logic                    rise, fall;
  logic                    load;
  logic [PERIOD_WIDTH-1:0] load_val;
  logic                    stall_set, stall_clr;

  logic                    out_valid_q;
  logic [PERIOD_WIDTH-1:0] out_period_q;
  logic                    stalled_q;
  logic                    overrun_q;

  // Hysteresis: only valid samples move the level; samples between the
  // thresholds can never flip it, so they never create a crossing.
  assign rise = bus.in_valid && !lvl && (bus.in_data >= HI);
  assign fall = bus.in_valid &&  lvl && (bus.in_data <= LO);

  // Timer holds cycles elapsed since the reference crossing, so on the next
  // crossing its current value is exactly the period. It counts clk cycles
  // regardless of in_valid.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx  = state;
    timer_nx  = timer;
    load      = 1'b0;
    load_val  = '0;
    stall_set = 1'b0;
    stall_clr = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (rise) begin
          state_nx  = RUN;
          timer_nx  = PERIOD_WIDTH'(1);
          stall_clr = 1'b1;
        end
      end
      RUN: begin
        if (rise) begin
          // A crossing on the timeout cycle wins over the timeout.
          load     = 1'b1;
          load_val = timer;
          timer_nx = PERIOD_WIDTH'(1);
        end else if (timer == TMO) begin
          state_nx  = IDLE;
          timer_nx  = '0;
          load      = 1'b1;
          load_val  = '0;
          stall_set = 1'b1;
        end else begin
          timer_nx = timer + PERIOD_WIDTH'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      lvl          <= 1'b0;
      out_valid_q  <= 1'b0;
      out_period_q <= '0;
      stalled_q    <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;

      if (rise)      lvl <= 1'b1;
      else if (fall) lvl <= 1'b0;

      if (stall_set)      stalled_q <= 1'b1;
      else if (stall_clr) stalled_q <= 1'b0;

      if (load) begin
        out_period_q <= load_val;
        out_valid_q  <= 1'b1;
        // Overwriting a result nobody has taken is the only overrun case;
        // a same-cycle handshake means the old value was consumed.
        if (out_valid_q && !bus.out_ready) overrun_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_period = out_period_q;
  assign bus.stalled    = stalled_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_crossing_period.sv
module tb_crossing_period;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  always #5 clk = ~clk;

  crossing_period_if #(.DATA_WIDTH(20), .PERIOD_WIDTH(32)) bus ();

  crossing_period #(
    .DATA_WIDTH(20), .PERIOD_WIDTH(32),
    .THRESH_HI(1000), .THRESH_LO(800), .TIMEOUT(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample, let one rising edge pass, return at the next
  // falling edge where registered outputs are settled.
  task automatic tick(input logic [19:0] d, input logic v);
    bus.in_data  = d;
    bus.in_valid = v;
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic [19:0] d);
    repeat (n) tick(d, 1'b1);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] chat [11];
    logic        v;
    logic [19:0] d;
    chat = '{20'd1200, 20'd900, 20'd1001, 20'd850, 20'd999,
             20'd900, 20'd1001, 20'd850, 20'd999, 20'd700, 20'd1200};

    // Reset values while rst is held
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_valid",   bus.out_valid,  0);
    check("rst_period",  bus.out_period, 0);
    check("rst_stalled", bus.stalled,    1);
    check("rst_overrun", bus.overrun,    0);
    do_reset();

    // Square wave: 50 low / 50 high, rises at 50,150,250,350
    pulses = 0;
    for (int k = 0; k < 400; k++) begin
      tick(((k % 100) >= 50) ? 20'd1200 : 20'd0, 1'b1);
      if (k == 50) begin
        check("sq_arm_valid",   bus.out_valid, 0);
        check("sq_arm_stalled", bus.stalled,   0);
      end
      if (k == 150 || k == 250 || k == 350) begin
        check("sq_valid",  bus.out_valid,  1);
        check("sq_period", bus.out_period, 100);
      end
      if (k == 151) check("sq_drop", bus.out_valid, 0);
      pulses += int'(bus.out_valid);
    end
    check("sq_pulses", pulses, 3);

    // Chatter between thresholds creates no crossing
    do_reset();
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      tick(chat[i], 1'b1);
      if (i < 10) pulses += int'(bus.out_valid);
    end
    check("chat_quiet",  pulses,         0);
    check("chat_valid",  bus.out_valid,  1);
    check("chat_period", bus.out_period, 10);

    // Backpressure: periods 100 then 120 with out_ready low
    do_reset();
    bus.out_ready = 1'b0;
    tick(20'd1200, 1'b1);
    ticks(99, 20'd0);
    tick(20'd1200, 1'b1);
    check("bp_p1",       bus.out_period, 100);
    check("bp_ovr0",     bus.overrun,    0);
    ticks(119, 20'd0);
    tick(20'd1200, 1'b1);
    check("bp_p2",       bus.out_period, 120);
    check("bp_valid",    bus.out_valid,  1);
    check("bp_overrun",  bus.overrun,    1);
    ticks(5, 20'd0);
    check("bp_hold",     bus.out_period, 120);
    bus.out_ready = 1'b1;
    tick(20'd0, 1'b1);
    check("bp_drop",     bus.out_valid,  0);
    check("bp_sticky",   bus.overrun,    1);

    // Timeout: zero-speed token, then re-arm
    do_reset();
    tick(20'd1200, 1'b1);
    ticks(999, 20'd0);
    check("to_pre_valid",   bus.out_valid, 0);
    check("to_pre_stalled", bus.stalled,   0);
    tick(20'd0, 1'b1);
    check("to_valid",   bus.out_valid,  1);
    check("to_period",  bus.out_period, 0);
    check("to_stalled", bus.stalled,    1);
    tick(20'd1200, 1'b1);
    check("to_rearm_valid",   bus.out_valid, 0);
    check("to_rearm_stalled", bus.stalled,   0);
    ticks(49, 20'd0);
    tick(20'd1200, 1'b1);
    check("to_next_valid",  bus.out_valid,  1);
    check("to_next_period", bus.out_period, 50);

    // Crossing on the exact timeout cycle wins
    do_reset();
    tick(20'd1200, 1'b1);
    ticks(999, 20'd0);
    tick(20'd1200, 1'b1);
    check("edge_period",  bus.out_period, 1000);
    check("edge_stalled", bus.stalled,    0);

    // Sparse samples; invalid cycles carry high data that must be ignored
    do_reset();
    for (int t = 0; t < 38; t++) begin
      v = (t == 37) || ((t % 4) == 0);
      d = (t == 0 || t == 37) ? 20'd1200 : (v ? 20'd0 : 20'd1200);
      tick(d, v);
      if (t == 36) check("sp_quiet", bus.out_valid, 0);
    end
    check("sp_valid",  bus.out_valid,  1);
    check("sp_period", bus.out_period, 37);

    // Async reset between edges with a pending result and overrun
    do_reset();
    bus.out_ready = 1'b0;
    tick(20'd1200, 1'b1);
    ticks(9, 20'd0);
    tick(20'd1200, 1'b1);
    ticks(4, 20'd0);
    tick(20'd1200, 1'b1);
    check("ar_pre_overrun", bus.overrun, 1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid",   bus.out_valid,  0);
    check("ar_overrun", bus.overrun,    0);
    check("ar_period",  bus.out_period, 0);
    check("ar_stalled", bus.stalled,    1);
    #1 rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    tick(20'd1200, 1'b1);
    check("ar_arm_valid", bus.out_valid, 0);
    ticks(19, 20'd0);
    tick(20'd1200, 1'b1);
    check("ar_period2", bus.out_period, 20);
    check("ar_valid2",  bus.out_valid,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
